// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide sequencer that stalls the pipeline while it works
module mdu_seq #(
    parameter int WORD_BITWIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [2:0]               funct3,
    input  logic [WORD_BITWIDTH-1:0] op_a,
    input  logic [WORD_BITWIDTH-1:0] op_b,
    input  logic                     flush,
    output logic                     stall,
    output logic                     done,
    output logic [WORD_BITWIDTH-1:0] result
);
    localparam int W  = WORD_BITWIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [2:0]      f3;
    logic [W-1:0]    ma, mb, abs_a, abs_b, special_res, final_res, q, r;
    logic            sa, neg, signed_a, signed_b, sign_a, sign_b;
    logic            accept, special, div_zero, div_ovf, last;
    logic [2*W-1:0]  acc, acc_step, mul_step, div_step, prod;
    logic [W:0]      sum, cand, diff;

    // operand decode, special-case detection and the per-cycle multiply/divide step
    always_comb begin
        signed_a    = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
        signed_b    = funct3[2] ? ~funct3[0] : ~funct3[1];
        sign_a      = signed_a & op_a[W-1];
        sign_b      = signed_b & op_b[W-1];
        abs_a       = sign_a ? -op_a : op_a;
        abs_b       = sign_b ? -op_b : op_b;
        div_zero    = funct3[2] & (op_b == '0);
        div_ovf     = funct3[2] & ~funct3[0] & (op_a == {1'b1, {(W-1){1'b0}}}) & (op_b == '1);
        special     = div_zero | div_ovf;
        special_res = div_zero ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);
        sum         = {1'b0, acc[2*W-1:W]} + {1'b0, acc[0] ? ma : '0};
        mul_step    = {sum, acc[W-1:1]};
        cand        = acc[2*W-1:W-1];
        diff        = cand - {1'b0, mb};
        div_step    = {diff[W] ? cand[W-1:0] : diff[W-1:0], acc[W-2:0], ~diff[W]};
        acc_step    = f3[2] ? div_step : mul_step;
        prod        = neg ? -acc_step : acc_step;
        q           = acc_step[W-1:0];
        r           = acc_step[2*W-1:W];
        final_res   = ~f3[2] ? ((f3[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W])
                             : (f3[1] ? (sa ? -r : r) : (neg ? -q : q));
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // next state, accept and handshake outputs
    always_comb begin
        accept     = rst_n & start & ~flush & (state != RUN);
        last       = cnt == CW'(W - 1);
        stall      = (state == RUN) | accept;
        done       = state == FIN;
        state_next = flush ? IDLE
                   : accept ? (special ? FIN : RUN)
                   : (state == RUN) ? (last ? FIN : RUN)
                   : IDLE;
    end

    // operand latch, iteration datapath and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            f3     <= '0;
            ma     <= '0;
            mb     <= '0;
            sa     <= 1'b0;
            neg    <= 1'b0;
            acc    <= '0;
            result <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
            f3  <= funct3;
            ma  <= abs_a;
            mb  <= abs_b;
            sa  <= sign_a;
            neg <= sign_a ^ sign_b;
            acc <= {{W{1'b0}}, funct3[2] ? abs_a : abs_b};
            if (special) result <= special_res;
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            acc <= acc_step;
            if (last) result <= final_res;
        end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed scoreboard bench for the multiply/divide sequencer
module tb_mdu_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        stall, done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    mdu_seq #(.WORD_BITWIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every done pulse must match the oldest pending expectation in value and cycle
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", result, e.res);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
    endtask

    task automatic wait_done(output int sc);
        bit seen = 0;
        sc = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                chk("stall_at_done", {31'd0, stall}, 32'd0);
            end else begin
                sc += int'(stall);
            end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        int sc;
        int n;
        issue(f, a, b);
        q.push_back('{exp, cyc + lat});
        @(negedge clk);
        n = int'(stall);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(sc);
        chk("stall_cycles", n + sc, lat);
    endtask

    initial begin
        int sc;
        int t0;
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        rst_n = 1'b1;

        run_op(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op(3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);
        run_op(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        run_op(3'b101, 32'd100, 32'd7, 32'd14, 33);
        run_op(3'b111, 32'd100, 32'd7, 32'd2, 33);

        // flush in cycle 10 of a divide: no done, result keeps 2
        issue(3'b100, 32'd1000, 32'd3);
        t0 = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        while (cyc < t0 + 10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_stall", {31'd0, stall}, 32'd0);
        repeat (40) @(negedge clk);
        chk("flush_result", result, 32'd2);

        // flush together with start is not accepted
        @(posedge clk);
        #1;
        start  = 1'b1;
        flush  = 1'b1;
        funct3 = 3'b000;
        #1 chk("flush_start_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_start_idle", {30'd0, stall, done}, 32'd0);

        run_op(3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        run_op(3'b110, 32'd5, 32'd0, 32'd5, 1);
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

        // start held high through RUN with changed operands is ignored
        issue(3'b000, 32'd6, 32'd9);
        q.push_back('{32'd54, cyc + 33});
        t0 = cyc;
        @(posedge clk);
        #1;
        op_a   = 32'd1000;
        funct3 = 3'b011;
        while (cyc < t0 + 32) @(posedge clk);
        #1 start = 1'b0;
        wait_done(sc);

        // back-to-back: start in the FIN cycle
        run_op(3'b000, 32'd11, 32'd13, 32'd143, 33);
        start  = 1'b1;
        funct3 = 3'b101;
        op_a   = 32'd50;
        op_b   = 32'd5;
        q.push_back('{32'd10, cyc + 33});
        #1 chk("b2b_stall", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(sc);
        chk("b2b_stall_cycles", sc, 32);

        // asynchronous reset in cycle 15 of a divide
        issue(3'b100, 32'd12345, 32'd7);
        t0 = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        while (cyc < t0 + 15) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'b000, 32'd3, 32'd4, 32'd12, 33);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
